// File: rtl/mul_pkg.sv
// Opcodes and FSM state encodings for the iterative multiplier.
// The opcodes are the same ones the ALU decoder uses.
package mul_pkg;

   localparam logic [2:0] OP_MUL   = 3'b101;
   localparam logic [2:0] OP_UMULL = 3'b110;
   localparam logic [2:0] OP_SMULL = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   function automatic logic is_mul_op(input logic [2:0] op);
      return (op == OP_MUL) || (op == OP_UMULL) || (op == OP_SMULL);
   endfunction

endpackage

// File: rtl/mul_seq_unit.sv
// Shift-add multiplier: one partial product per cycle for WIDTH cycles, then a sign fix-up
// for SMULL, then a one-cycle done pulse with lo/hi halves and N/Z flags.
module mul_seq_unit
   import mul_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             flag_n,
   output logic             flag_z
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t               state_q, state_d;
   logic [2:0]           op_q, op_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplr_q, mplr_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 neg_q, neg_d;
   logic [WIDTH-1:0]     result_lo_q, result_lo_d;
   logic [WIDTH-1:0]     result_hi_q, result_hi_d;
   logic                 flag_n_q, flag_n_d;
   logic                 flag_z_q, flag_z_d;

   logic                 is_smull;
   logic [WIDTH-1:0]     abs_a, abs_b;
   logic [2*WIDTH-1:0]   fixed;

   // Magnitudes are held unsigned, so the most negative operand maps onto itself correctly.
   assign is_smull = (op == OP_SMULL);
   assign abs_a    = (is_smull && a[WIDTH-1]) ? (~a + 1'b1) : a;
   assign abs_b    = (is_smull && b[WIDTH-1]) ? (~b + 1'b1) : b;
   assign fixed    = neg_q ? (~acc_q + 1'b1) : acc_q;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      mcand_d     = mcand_q;
      mplr_d      = mplr_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      neg_d       = neg_q;
      result_lo_d = result_lo_q;
      result_hi_d = result_hi_q;
      flag_n_d    = flag_n_q;
      flag_z_d    = flag_z_q;

      unique case (state_q)
         S_IDLE: begin
            if (start && is_mul_op(op)) begin
               state_d     = S_CALC;
               op_d        = op;
               mcand_d     = {{WIDTH{1'b0}}, abs_a};
               mplr_d      = abs_b;
               neg_d       = is_smull && (a[WIDTH-1] ^ b[WIDTH-1]);
               acc_d       = '0;
               cnt_d       = '0;
               result_lo_d = '0;
               result_hi_d = '0;
               flag_n_d    = 1'b0;
               flag_z_d    = 1'b0;
            end
         end
         S_CALC: begin
            // mcand_q is kept pre-shifted, equivalent to adding mcand << cnt.
            if (mplr_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            acc_d       = fixed;
            result_lo_d = fixed[WIDTH-1:0];
            if (op_q == OP_MUL) begin
               result_hi_d = '0;
               flag_n_d    = fixed[WIDTH-1];
               flag_z_d    = (fixed[WIDTH-1:0] == '0);
            end else begin
               result_hi_d = fixed[2*WIDTH-1:WIDTH];
               flag_n_d    = fixed[2*WIDTH-1];
               flag_z_d    = (fixed == '0);
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         mcand_q     <= '0;
         mplr_q      <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         neg_q       <= 1'b0;
         result_lo_q <= '0;
         result_hi_q <= '0;
         flag_n_q    <= 1'b0;
         flag_z_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         mcand_q     <= mcand_d;
         mplr_q      <= mplr_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         neg_q       <= neg_d;
         result_lo_q <= result_lo_d;
         result_hi_q <= result_hi_d;
         flag_n_q    <= flag_n_d;
         flag_z_q    <= flag_z_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign result_lo = result_lo_q;
   assign result_hi = result_hi_q;
   assign flag_n    = flag_n_q;
   assign flag_z    = flag_z_q;

endmodule

// File: tb/tb_mul_seq_unit.sv
// Directed bench for mul_seq_unit: hand-computed products, latency, ignored requests and reset abort.
module tb_mul_seq_unit;

   localparam int W = 32;
   localparam int LAT = W + 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [2:0]    op = 3'b000;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          busy, done;
   logic [W-1:0]  result_lo, result_hi;
   logic          flag_n, flag_z;

   int checks = 0;
   int failures = 0;

   mul_seq_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result_lo (result_lo),
      .result_hi (result_hi),
      .flag_n    (flag_n),
      .flag_z    (flag_z)
   );

   always #5 clk = ~clk;

   // Issues one request and waits (bounded) for done; cycle 1 is the cycle after acceptance.
   task automatic run_op(input logic [2:0] o, input logic [W-1:0] ra, input logic [W-1:0] rb,
                         output int cyc, output logic [W-1:0] lo, output logic [W-1:0] hi,
                         output logic n, output logic z, output logic busy1);
      @(negedge clk);
      start = 1'b1; op = o; a = ra; b = rb;
      @(posedge clk);
      #1;
      start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1357_9BDF;
      cyc = -1; lo = 'x; hi = 'x; n = 1'bx; z = 1'bx; busy1 = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (i == 1) busy1 = busy;
         if (done) begin
            cyc = i; lo = result_lo; hi = result_hi; n = flag_n; z = flag_z;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, result_lo, result_hi, flag_n, flag_z} !== '0) begin
         failures++;
         $display("FAIL reset_outputs busy=%b done=%b lo=%h hi=%h n=%b z=%b required all 0",
                  busy, done, result_lo, result_hi, flag_n, flag_z);
      end
      reset = 1'b1;
      @(negedge clk);
      $display("reset: busy=%b done=%b lo=%h hi=%h", busy, done, result_lo, result_hi);
   endtask

   task automatic test_mul();
      int cyc; logic [W-1:0] lo, hi; logic n, z, b1;
      run_op(3'b101, 32'd7, 32'd6, cyc, lo, hi, n, z, b1);
      $display("MUL 7*6: cycle=%0d lo=%h hi=%h n=%b z=%b", cyc, lo, hi, n, z);
      checks++;
      if (cyc !== LAT) begin failures++; $display("FAIL mul_latency got %0d required %0d", cyc, LAT); end
      checks++;
      if (b1 !== 1'b1) begin failures++; $display("FAIL mul_busy got %b required 1", b1); end
      checks++;
      if ({lo, hi, n, z} !== {32'h0000_002A, 32'h0, 1'b0, 1'b0}) begin
         failures++; $display("FAIL mul_result lo=%h hi=%h n=%b z=%b required 2a/0/0/0", lo, hi, n, z);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, result_lo} !== {1'b0, 1'b0, 32'h0000_002A}) begin
         failures++; $display("FAIL mul_hold busy=%b done=%b lo=%h required 0/0/2a", busy, done, result_lo);
      end
   endtask

   task automatic test_umull();
      int cyc; logic [W-1:0] lo, hi; logic n, z, b1;
      run_op(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, lo, hi, n, z, b1);
      $display("UMULL ffffffff^2: cycle=%0d hi=%h lo=%h n=%b z=%b", cyc, hi, lo, n, z);
      checks++;
      if ({cyc == LAT, hi, lo, n, z} !== {1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0}) begin
         failures++; $display("FAIL umull_result cyc=%0d hi=%h lo=%h n=%b z=%b required %0d/fffffffe/00000001/1/0",
                              cyc, hi, lo, n, z, LAT);
      end
   endtask

   task automatic test_smull();
      int cyc; logic [W-1:0] lo, hi; logic n, z, b1;
      run_op(3'b111, 32'hFFFF_FFFF, 32'd2, cyc, lo, hi, n, z, b1);
      $display("SMULL -1*2: cycle=%0d hi=%h lo=%h n=%b z=%b", cyc, hi, lo, n, z);
      checks++;
      if ({hi, lo, n, z} !== {32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0}) begin
         failures++; $display("FAIL smull_neg hi=%h lo=%h n=%b z=%b required ffffffff/fffffffe/1/0", hi, lo, n, z);
      end
      run_op(3'b111, 32'h8000_0000, 32'h8000_0000, cyc, lo, hi, n, z, b1);
      $display("SMULL min*min: cycle=%0d hi=%h lo=%h n=%b z=%b", cyc, hi, lo, n, z);
      checks++;
      if ({hi, lo, n, z} !== {32'h4000_0000, 32'h0, 1'b0, 1'b0}) begin
         failures++; $display("FAIL smull_min hi=%h lo=%h n=%b z=%b required 40000000/0/0/0", hi, lo, n, z);
      end
      run_op(3'b111, 32'hFFFF_FFFD, 32'h0000_0005, cyc, lo, hi, n, z, b1);
      $display("SMULL -3*5: cycle=%0d hi=%h lo=%h n=%b z=%b", cyc, hi, lo, n, z);
      checks++;
      if ({hi, lo, n} !== {32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1}) begin
         failures++; $display("FAIL smull_mixed hi=%h lo=%h n=%b required ffffffff/fffffff1/1", hi, lo, n);
      end
   endtask

   task automatic test_zero_and_bad_op();
      int cyc; logic [W-1:0] lo, hi; logic n, z, b1;
      int saw_busy, saw_done;
      run_op(3'b101, 32'd0, 32'h1234, cyc, lo, hi, n, z, b1);
      $display("MUL 0*1234: cycle=%0d lo=%h hi=%h n=%b z=%b", cyc, lo, hi, n, z);
      checks++;
      if ({lo, hi, n, z} !== {32'h0, 32'h0, 1'b0, 1'b1}) begin
         failures++; $display("FAIL mul_zero lo=%h hi=%h n=%b z=%b required 0/0/0/1", lo, hi, n, z);
      end
      @(negedge clk);
      start = 1'b1; op = 3'b100; a = 32'd3; b = 32'd4;
      saw_busy = 0; saw_done = 0;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         if (i == 0) start = 1'b0;
         if (busy) saw_busy++;
         if (done) saw_done++;
      end
      $display("op=100: busy_cycles=%0d done_cycles=%0d", saw_busy, saw_done);
      checks++;
      if (saw_busy != 0 || saw_done != 0) begin
         failures++; $display("FAIL bad_op busy_cycles=%0d done_cycles=%0d required 0/0", saw_busy, saw_done);
      end
   endtask

   task automatic test_back_to_back();
      int done_cnt, first_done;
      logic [W-1:0] lo, hi;
      @(negedge clk);
      start = 1'b1; op = 3'b101; a = 32'd5; b = 32'd9;
      @(posedge clk);
      #1 start = 1'b0;
      done_cnt = 0; first_done = -1; lo = 'x; hi = 'x;
      for (int i = 1; i <= 70; i++) begin
         @(negedge clk);
         if (i == 10) begin
            start = 1'b1; op = 3'b110; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            done_cnt++;
            if (first_done < 0) begin first_done = i; lo = result_lo; hi = result_hi; end
         end
      end
      $display("start while busy: done_pulses=%0d first_done=%0d lo=%h hi=%h", done_cnt, first_done, lo, hi);
      checks++;
      if (done_cnt != 1 || first_done != LAT) begin
         failures++; $display("FAIL busy_start done_pulses=%0d at=%0d required 1 at %0d", done_cnt, first_done, LAT);
      end
      checks++;
      if ({lo, hi} !== {32'd45, 32'd0}) begin
         failures++; $display("FAIL busy_start_result lo=%h hi=%h required 2d/0", lo, hi);
      end
   endtask

   task automatic test_reset_mid_op();
      int cyc, saw_done; logic [W-1:0] lo, hi; logic n, z, b1;
      @(negedge clk);
      start = 1'b1; op = 3'b110; a = 32'h0001_0000; b = 32'h0001_0000;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (15) @(negedge clk);
      reset = 1'b0;
      #1;
      $display("reset mid-op: busy=%b done=%b lo=%h hi=%h", busy, done, result_lo, result_hi);
      checks++;
      if ({busy, done, result_lo, result_hi, flag_n, flag_z} !== '0) begin
         failures++; $display("FAIL reset_abort busy=%b done=%b lo=%h hi=%h n=%b z=%b required all 0",
                              busy, done, result_lo, result_hi, flag_n, flag_z);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      saw_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) saw_done++;
      end
      checks++;
      if (saw_done != 0) begin
         failures++; $display("FAIL reset_no_done active_cycles=%0d required 0", saw_done);
      end
      run_op(3'b101, 32'd3, 32'd3, cyc, lo, hi, n, z, b1);
      $display("MUL 3*3 after reset: cycle=%0d lo=%h hi=%h", cyc, lo, hi);
      checks++;
      if ({cyc == LAT, lo, hi} !== {1'b1, 32'd9, 32'd0}) begin
         failures++; $display("FAIL after_reset cyc=%0d lo=%h hi=%h required %0d/9/0", cyc, lo, hi, LAT);
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_umull();
      test_smull();
      test_zero_and_bad_op();
      test_back_to_back();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
